// File: rtl/plab4_net_ni_adapter.sv
// plab4_net_ni_adapter
//   Network interface between one terminal and its ring router.
//   Injection path: terminal requests are stamped {dest, router id, tag,
//   payload} and queued in a 2-entry FIFO towards the ring.
//   Ejection path: ring messages addressed to this router are queued in a
//   2-entry FIFO and presented to the terminal. Misaddressed ones are dropped.
//
// Ports
//   clk, reset (async, active-low)
//   term_req_*  : terminal request in (val/rdy, dest, payload)
//   net_in_*    : message out to the ring injection port (val/rdy, msg)
//   net_out_*   : message in from the ring ejection port (val/rdy, msg)
//   term_resp_* : delivery to the terminal (val/rdy, src, opaque, payload)
//   err_bad_dest, err_misroute : sticky error flags
//   inj_count, ej_count        : saturating message counters
//   net msg layout = {dest, src, opaque, payload}, dest at the MSB

module plab4_net_ni_adapter #(
  parameter int unsigned p_payload_nbits = 32,
  parameter int unsigned p_opaque_nbits  = 3,
  parameter int unsigned p_srcdest_nbits = 3,
  parameter int unsigned p_router_id     = 0,
  parameter int unsigned p_num_routers   = 8
)(
  input  logic                                                  clk,
  input  logic                                                  reset,

  input  logic                                                  term_req_val,
  output logic                                                  term_req_rdy,
  input  logic [p_srcdest_nbits-1:0]                            term_req_dest,
  input  logic [p_payload_nbits-1:0]                            term_req_payload,

  output logic                                                  net_in_val,
  input  logic                                                  net_in_rdy,
  output logic [2*p_srcdest_nbits+p_opaque_nbits+p_payload_nbits-1:0] net_in_msg,

  input  logic                                                  net_out_val,
  output logic                                                  net_out_rdy,
  input  logic [2*p_srcdest_nbits+p_opaque_nbits+p_payload_nbits-1:0] net_out_msg,

  output logic                                                  term_resp_val,
  input  logic                                                  term_resp_rdy,
  output logic [p_srcdest_nbits-1:0]                            term_resp_src,
  output logic [p_opaque_nbits-1:0]                             term_resp_opaque,
  output logic [p_payload_nbits-1:0]                            term_resp_payload,

  output logic                                                  err_bad_dest,
  output logic                                                  err_misroute,
  output logic [15:0]                                           inj_count,
  output logic [15:0]                                           ej_count
);

  localparam int unsigned c_s     = p_srcdest_nbits;
  localparam int unsigned c_o     = p_opaque_nbits;
  localparam int unsigned c_p     = p_payload_nbits;
  localparam int unsigned c_m     = 2*c_s + c_o + c_p;
  localparam int unsigned c_ej_w  = c_s + c_o + c_p;

  localparam logic [c_s-1:0] c_router_id   = c_s'(p_router_id);
  localparam logic [31:0]    c_num_routers = 32'(p_num_routers);

  // Held low through reset and released by the first clock edge afterwards,
  // so both rdy outputs stay low while reset is asserted.
  logic live;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) live <= 1'b0;
    else        live <= 1'b1;
  end

  // ---------------- injection path ----------------
  logic [c_m-1:0] inj_q [2];
  logic           inj_wp, inj_rp;
  logic [1:0]     inj_cnt;
  logic [c_o-1:0] tag;
  logic           req_fire, dest_ok, inj_enq, inj_deq;

  assign dest_ok      = 32'(term_req_dest) < c_num_routers;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign term_req_rdy = live & ((inj_cnt != 2'd2) | net_in_rdy);
  assign req_fire     = term_req_val & term_req_rdy;
  assign inj_enq      = req_fire & dest_ok;
  assign net_in_val   = (inj_cnt != 2'd0);
  assign inj_deq      = net_in_val & net_in_rdy;
  assign net_in_msg   = inj_q[inj_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_wp       <= 1'b0;
      inj_rp       <= 1'b0;
      inj_cnt      <= '0;
      tag          <= '0;
      err_bad_dest <= 1'b0;
      inj_count    <= '0;
    end else begin
      if (inj_enq) inj_wp <= ~inj_wp;
      if (inj_deq) inj_rp <= ~inj_rp;
      inj_cnt <= inj_cnt + 2'(inj_enq) - 2'(inj_deq);
      // Bad-dest requests are accepted, so they consume a tag too.
      if (req_fire) tag <= tag + 1'b1;
      if (req_fire && !dest_ok) err_bad_dest <= 1'b1;
      if (inj_deq && inj_count != '1) inj_count <= inj_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (inj_enq) inj_q[inj_wp] <= {term_req_dest, c_router_id, tag, term_req_payload};
  end

  // ---------------- ejection path ----------------
  logic [c_ej_w-1:0] ej_q [2];
  logic              ej_wp, ej_rp;
  logic [1:0]        ej_cnt;
  logic              for_me, ej_fire, ej_enq, ej_deq;

  assign for_me        = (net_out_msg[c_m-1 -: c_s] == c_router_id);
  // Misaddressed messages are always taken (and dropped), even when full.
  assign net_out_rdy   = live & (~for_me | (ej_cnt != 2'd2) | term_resp_rdy);
  assign ej_fire       = net_out_val & net_out_rdy;
  assign ej_enq        = ej_fire & for_me;
  assign term_resp_val = (ej_cnt != 2'd0);
  assign ej_deq        = term_resp_val & term_resp_rdy;

  assign {term_resp_src, term_resp_opaque, term_resp_payload} = ej_q[ej_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ej_wp        <= 1'b0;
      ej_rp        <= 1'b0;
      ej_cnt       <= '0;
      err_misroute <= 1'b0;
      ej_count     <= '0;
    end else begin
      if (ej_enq) ej_wp <= ~ej_wp;
      if (ej_deq) ej_rp <= ~ej_rp;
      ej_cnt <= ej_cnt + 2'(ej_enq) - 2'(ej_deq);
      if (ej_fire && !for_me) err_misroute <= 1'b1;
      if (ej_deq && ej_count != '1) ej_count <= ej_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (ej_enq) ej_q[ej_wp] <= net_out_msg[c_ej_w-1:0];
  end

endmodule

// File: tb/tb_plab4_net_ni_adapter.sv
module tb_plab4_net_ni_adapter;

  localparam int unsigned S = 4;
  localparam int unsigned O = 3;
  localparam int unsigned P = 32;
  localparam int unsigned M = 2*S + O + P;

  logic          clk = 1'b0;
  logic          reset;
  logic          term_req_val;
  logic          term_req_rdy;
  logic [S-1:0]  term_req_dest;
  logic [P-1:0]  term_req_payload;
  logic          net_in_val;
  logic          net_in_rdy;
  logic [M-1:0]  net_in_msg;
  logic          net_out_val;
  logic          net_out_rdy;
  logic [M-1:0]  net_out_msg;
  logic          term_resp_val;
  logic          term_resp_rdy;
  logic [S-1:0]  term_resp_src;
  logic [O-1:0]  term_resp_opaque;
  logic [P-1:0]  term_resp_payload;
  logic          err_bad_dest;
  logic          err_misroute;
  logic [15:0]   inj_count;
  logic [15:0]   ej_count;

  int n_assert = 0;
  int n_fail   = 0;

  plab4_net_ni_adapter #(
    .p_payload_nbits (P),
    .p_opaque_nbits  (O),
    .p_srcdest_nbits (S),
    .p_router_id     (2),
    .p_num_routers   (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .term_req_val      (term_req_val),
    .term_req_rdy      (term_req_rdy),
    .term_req_dest     (term_req_dest),
    .term_req_payload  (term_req_payload),
    .net_in_val        (net_in_val),
    .net_in_rdy        (net_in_rdy),
    .net_in_msg        (net_in_msg),
    .net_out_val       (net_out_val),
    .net_out_rdy       (net_out_rdy),
    .net_out_msg       (net_out_msg),
    .term_resp_val     (term_resp_val),
    .term_resp_rdy     (term_resp_rdy),
    .term_resp_src     (term_resp_src),
    .term_resp_opaque  (term_resp_opaque),
    .term_resp_payload (term_resp_payload),
    .err_bad_dest      (err_bad_dest),
    .err_misroute      (err_misroute),
    .inj_count         (inj_count),
    .ej_count          (ej_count)
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] mk(input logic [S-1:0] d, input logic [S-1:0] s,
                                      input logic [O-1:0] o, input logic [P-1:0] p);
    return {d, s, o, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic req(input logic [S-1:0] d, input logic [P-1:0] p);
    term_req_val     = 1'b1;
    term_req_dest    = d;
    term_req_payload = p;
  endtask

  logic [O-1:0] tag_exp;

  initial begin
    reset = 1'b0;
    term_req_val = 1'b0; term_req_dest = '0; term_req_payload = '0;
    net_in_rdy = 1'b0;
    net_out_val = 1'b0; net_out_msg = '0;
    term_resp_rdy = 1'b0;

    // ---- reset state ----
    step(); step();
    chk("rst_net_in_val", 64'(net_in_val), 64'd0);
    chk("rst_term_resp_val", 64'(term_resp_val), 64'd0);
    chk("rst_term_req_rdy", 64'(term_req_rdy), 64'd0);
    chk("rst_net_out_rdy", 64'(net_out_rdy), 64'd0);
    chk("rst_inj_count", 64'(inj_count), 64'd0);
    chk("rst_ej_count", 64'(ej_count), 64'd0);
    chk("rst_err_bad_dest", 64'(err_bad_dest), 64'd0);
    chk("rst_err_misroute", 64'(err_misroute), 64'd0);
    #3 reset = 1'b1;
    #1 chk("rel_rdy_before_edge", 64'(term_req_rdy), 64'd0);
    step();
    chk("rel_term_req_rdy", 64'(term_req_rdy), 64'd1);
    chk("rel_net_out_rdy", 64'(net_out_rdy), 64'd1);

    // ---- single inject (tag 0) ----
    net_in_rdy = 1'b1;
    req(4'd5, 32'hCAFE0001);
    step();
    term_req_val = 1'b0;
    chk("inj1_val", 64'(net_in_val), 64'd1);
    chk("inj1_msg", 64'(net_in_msg), 64'(mk(4'd5, 4'd2, 3'd0, 32'hCAFE0001)));
    chk("inj1_count_pre", 64'(inj_count), 64'd0);
    step();
    chk("inj1_val_after", 64'(net_in_val), 64'd0);
    chk("inj1_count", 64'(inj_count), 64'd1);

    // ---- backpressure: tags 1,2,3 ----
    net_in_rdy = 1'b0;
    req(4'd1, 32'hA0);
    step();
    req(4'd3, 32'hB0);
    #1 chk("bp_rdy_second", 64'(term_req_rdy), 64'd1);
    step();
    req(4'd4, 32'hC0);
    #1 chk("bp_rdy_full", 64'(term_req_rdy), 64'd0);
    chk("bp_head_a", 64'(net_in_msg), 64'(mk(4'd1, 4'd2, 3'd1, 32'hA0)));
    step();
    chk("bp_rdy_still_full", 64'(term_req_rdy), 64'd0);
    net_in_rdy = 1'b1;
    #1 chk("bp_rdy_full_with_deq", 64'(term_req_rdy), 64'd1);
    step();
    term_req_val = 1'b0;
    chk("bp_head_b", 64'(net_in_msg), 64'(mk(4'd3, 4'd2, 3'd2, 32'hB0)));
    chk("bp_count_2", 64'(inj_count), 64'd2);
    step();
    chk("bp_head_c", 64'(net_in_msg), 64'(mk(4'd4, 4'd2, 3'd3, 32'hC0)));
    step();
    chk("bp_empty", 64'(net_in_val), 64'd0);
    chk("bp_count_4", 64'(inj_count), 64'd4);

    // ---- tag wrap: 9 back-to-back requests, tags 4..7,0..4 ----
    tag_exp = 3'd4;
    for (int i = 0; i < 9; i++) begin
      req(4'(i % 8), 32'h100 + 32'(i));
      step();
      chk($sformatf("wrap_msg_%0d", i), 64'(net_in_msg),
          64'(mk(4'(i % 8), 4'd2, tag_exp, 32'h100 + 32'(i))));
      tag_exp = tag_exp + 3'd1;
    end
    term_req_val = 1'b0;
    step();
    chk("wrap_empty", 64'(net_in_val), 64'd0);
    chk("wrap_count", 64'(inj_count), 64'd13);

    // ---- bad destinations 9 and 8 consume tags 5,6; dest 7 gets tag 7 ----
    req(4'd9, 32'hDEAD0009);
    #1 chk("bad9_rdy", 64'(term_req_rdy), 64'd1);
    step();
    chk("bad9_no_val", 64'(net_in_val), 64'd0);
    chk("bad9_err", 64'(err_bad_dest), 64'd1);
    req(4'd8, 32'hDEAD0008);
    step();
    chk("bad8_no_val", 64'(net_in_val), 64'd0);
    req(4'd7, 32'hBEEF);
    step();
    term_req_val = 1'b0;
    chk("dest7_msg", 64'(net_in_msg), 64'(mk(4'd7, 4'd2, 3'd7, 32'hBEEF)));
    step();
    chk("dest7_count", 64'(inj_count), 64'd14);
    chk("bad_err_sticky", 64'(err_bad_dest), 64'd1);

    // ---- single eject ----
    term_resp_rdy = 1'b1;
    net_out_val = 1'b1;
    net_out_msg = mk(4'd2, 4'd6, 3'd3, 32'h1234);
    #1 chk("ej1_rdy", 64'(net_out_rdy), 64'd1);
    step();
    net_out_val = 1'b0;
    chk("ej1_val", 64'(term_resp_val), 64'd1);
    chk("ej1_fields", {term_resp_src, term_resp_opaque, term_resp_payload},
        {4'd6, 3'd3, 32'h1234});
    chk("ej1_count_pre", 64'(ej_count), 64'd0);
    step();
    chk("ej1_val_after", 64'(term_resp_val), 64'd0);
    chk("ej1_count", 64'(ej_count), 64'd1);

    // ---- eject backpressure, stability, misroute while full ----
    term_resp_rdy = 1'b0;
    net_out_val = 1'b1;
    net_out_msg = mk(4'd2, 4'd1, 3'd1, 32'h11);
    step();
    net_out_msg = mk(4'd2, 4'd4, 3'd5, 32'h22);
    step();
    net_out_msg = mk(4'd2, 4'd7, 3'd0, 32'h33);
    #1 chk("ejbp_rdy_full", 64'(net_out_rdy), 64'd0);
    step();
    chk("ejbp_head_stable", {term_resp_src, term_resp_opaque, term_resp_payload},
        {4'd1, 3'd1, 32'h11});
    net_out_msg = mk(4'd4, 4'd3, 3'd2, 32'h44);
    #1 chk("mis_rdy_when_full", 64'(net_out_rdy), 64'd1);
    step();
    chk("mis_err", 64'(err_misroute), 64'd1);
    chk("mis_head_unchanged", 64'(term_resp_payload), 64'h11);
    // full FIFO with simultaneous delivery accepts M3
    net_out_msg = mk(4'd2, 4'd7, 3'd0, 32'h33);
    term_resp_rdy = 1'b1;
    #1 chk("ejbp_rdy_full_with_deq", 64'(net_out_rdy), 64'd1);
    step();
    net_out_val = 1'b0;
    chk("ej_order_2", {term_resp_src, term_resp_opaque, term_resp_payload},
        {4'd4, 3'd5, 32'h22});
    step();
    chk("ej_order_3", {term_resp_src, term_resp_opaque, term_resp_payload},
        {4'd7, 3'd0, 32'h33});
    step();
    chk("ej_drained", 64'(term_resp_val), 64'd0);
    chk("ej_count_4", 64'(ej_count), 64'd4);
    chk("mis_err_sticky", 64'(err_misroute), 64'd1);

    // ---- reset mid-traffic, both paths loaded in the same cycles ----
    net_in_rdy = 1'b0;
    term_resp_rdy = 1'b0;
    req(4'd1, 32'h51);
    net_out_val = 1'b1;
    net_out_msg = mk(4'd2, 4'd5, 3'd1, 32'h61);
    step();
    req(4'd1, 32'h52);
    net_out_msg = mk(4'd2, 4'd5, 3'd2, 32'h62);
    step();
    term_req_val = 1'b0;
    net_out_val = 1'b0;
    chk("mid_inj_full", 64'(term_req_rdy), 64'd0);
    chk("mid_ej_full_val", 64'(term_resp_val), 64'd1);
    #3 reset = 1'b0;
    #1;
    chk("arst_net_in_val", 64'(net_in_val), 64'd0);
    chk("arst_term_resp_val", 64'(term_resp_val), 64'd0);
    chk("arst_net_out_rdy", 64'(net_out_rdy), 64'd0);
    chk("arst_counts", {inj_count, ej_count}, 64'd0);
    chk("arst_flags", {err_bad_dest, err_misroute}, 64'd0);
    step(); step();
    #3 reset = 1'b1;
    step();
    net_in_rdy = 1'b1;
    term_resp_rdy = 1'b1;
    step(); step();
    chk("post_no_inj", 64'(net_in_val), 64'd0);
    chk("post_no_ej", 64'(term_resp_val), 64'd0);
    chk("post_counts", {inj_count, ej_count}, 64'd0);
    req(4'd3, 32'h77);
    step();
    term_req_val = 1'b0;
    chk("post_tag_restart", 64'(net_in_msg), 64'(mk(4'd3, 4'd2, 3'd0, 32'h77)));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
